xor_arbiter: RTL and testbench
==============================

Name: xor_arbiter

Overview:
- Shares one 16-bit XOR datapath (y = a ^ b) between NREQ requesters.
- Arbitration is round-robin; each requester presents an operand pair.
- The winner's result is captured in a single output register, tagged with the winner's index, and held until the downstream consumer accepts it.
- Sits between the requesting datapath units and the shared XOR resource.

Parameters:
- NREQ, 4, number of requesters; legal 2..8.
- WIDTH, 16, operand and result width in bits.
- IDW, $clog2(NREQ), width of the requester index. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester request; bit i qualifies slice i of a_in/b_in.
- a_in  input  NREQ*WIDTH  operand A; requester i occupies [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand B; same packing as a_in.
- gnt  output  NREQ  one-hot combinational accept pulse. A requester whose bit is high has its operands consumed at this clock edge.
- y_out  output  WIDTH  registered result a ^ b of the granted requester.
- y_id  output  IDW  index of the requester that produced y_out.
- y_valid  output  1  y_out/y_id hold a result not yet accepted.
- y_ready  input  1  consumer accepts the result when y_valid && y_ready.

Behaviour:
- States:
  - IDLE: output register empty.
  - HOLD: result pending.
- Transitions:
  - IDLE -> HOLD on any grant.
  - HOLD -> IDLE on accept with no new grant.
  - HOLD -> HOLD on accept with a new grant in the same cycle (back-to-back).
  - HOLD -> HOLD without accept (stall).
- free = (state==IDLE) || y_ready.
- A grant is issued only when free && |req.
- Winner selection: first set bit of req at or after rr_ptr, searching upward with wrap to 0 after NREQ-1.
- gnt is combinational from req, rr_ptr and state.
  - Zero when not free.
  - Zero when req == 0.
  - Never more than one bit set.
- On the grant edge:
  - y_out <= a_i ^ b_i for winner i.
  - y_id <= i.
  - y_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Latency: request granted in cycle N gives y_valid=1 with its result from cycle N+1.
- Throughput: one result per cycle while y_ready is held high.
- Accept without a new grant: y_valid <= 0 at the edge. y_out and y_id keep their last values and are don't-care while y_valid=0.
- Stall (y_valid=1, y_ready=0):
  - y_out, y_id and y_valid hold.
  - gnt = 0.
  - rr_ptr holds.
  - Requesters keep req asserted; operands may change freely until granted.
- rr_ptr changes only on a grant. Dropping req while waiting carries no penalty.
- Fairness: a continuously asserted request is granted within NREQ grants.
- Reset (rst=1 at an edge), including mid-HOLD: in-flight result is discarded.
  - state=IDLE, rr_ptr=0.
  - y_valid=0, y_out=0, y_id=0.
  - gnt=0 while rst is high.
- XOR is bitwise over the full WIDTH; no carry and no width extension.

Optional Feature:
- Macro: XOR_ARBITER_STATS_EN.
- When defined, adds output grant_cnt (16 bits): total grants since reset.
  - Increments by 1 on every grant edge.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst.
- Also adds input stats_clr (1 bit):
  - Synchronously zeroes grant_cnt.
  - Takes priority over an increment in the same cycle.
- When not defined, neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Single request: after reset, req=4'b0010, a1=16'hA5A5, b1=16'h0FF0, y_ready=1.
  - gnt=4'b0010 that cycle.
  - Next cycle y_valid=1, y_out=16'hAA55, y_id=1.
  - Following cycle y_valid=0.
- Round-robin: req=4'b1111 held, y_ready=1 for 5 cycles. Grants are in order 0,1,2,3,0; y_id sequence is 0,1,2,3,0 with y_valid continuously 1.
- Wrap: rr_ptr=3 (after granting 2), req=4'b0101. Grant goes to 0, then to 2.
- Back-pressure: y_ready=0 for 3 cycles with req=4'b0011 pending.
  - y_out, y_id and y_valid are stable.
  - gnt=0.
  - Raising y_ready accepts and grants requester 1 in the same cycle.
  - Next result is valid the following cycle.
- Reset mid-HOLD: y_valid=1, y_ready=0, then rst=1 for one cycle.
  - y_valid=0, y_out=0, rr_ptr=0.
  - Next req=4'b1000 is granted to requester 3.
- XOR_ARBITER_STATS_EN:
  - 70000 grants: grant_cnt=16'hFFFF.
  - stats_clr asserted during a grant: grant_cnt=0.

Source files
------------

// File: rtl/xor_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit XOR datapath between NREQ requesters,
// with a single held output register. Optional grant counter: define XOR_ARBITER_STATS_EN.
module xor_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 16,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        y_out,
    output logic [IDW-1:0]          y_id,
    output logic                    y_valid,
    input  logic                    y_ready
`ifdef XOR_ARBITER_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [15:0]             grant_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [WIDTH-1:0] y_out_r;
    logic [IDW-1:0]   y_id_r;
    logic [IDW-1:0]   win_idx_s;
    logic             win_found_s;
    logic [IDW:0]     cand_s;
    logic             free_s;
    logic             grant_s;

    // Pointer to the requester just after the winner, wrapping at NREQ-1.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
        logic [IDW-1:0] nxt;
        if (idx == IDW'(NREQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + {{(IDW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Round-robin search: scan offsets high-to-low so the nearest set bit at/after rr_ptr wins.
    always_comb begin
        win_idx_s   = '0;
        win_found_s = 1'b0;
        cand_s      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (cand_s >= (IDW+1)'(NREQ)) begin
                cand_s = cand_s - (IDW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[IDW-1:0]]) begin
                win_idx_s   = cand_s[IDW-1:0];
                win_found_s = 1'b1;
            end else begin
                win_idx_s   = win_idx_s;
                win_found_s = win_found_s;
            end
        end
    end

    assign free_s  = (state_r == ST_IDLE) || y_ready;
    assign grant_s = free_s && win_found_s && !rst;

    // One-hot accept pulse for the winner.
    always_comb begin
        gnt = '0;
        if (grant_s) begin
            gnt[win_idx_s] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

    // Output register, occupancy state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            y_out_r  <= '0;
            y_id_r   <= '0;
        end else if (grant_s) begin
            state_r  <= ST_HOLD;
            rr_ptr_r <= next_ptr(win_idx_s);
            y_out_r  <= a_in[int'(win_idx_s)*WIDTH +: WIDTH] ^ b_in[int'(win_idx_s)*WIDTH +: WIDTH];
            y_id_r   <= win_idx_s;
        end else if ((state_r == ST_HOLD) && y_ready) begin
            state_r  <= ST_IDLE;
        end
    end

    assign y_out   = y_out_r;
    assign y_id    = y_id_r;
    assign y_valid = (state_r == ST_HOLD);

`ifdef XOR_ARBITER_STATS_EN
    logic [15:0] grant_cnt_r;

    // Saturating grant counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_r <= 16'h0000;
        end else if (stats_clr) begin
            grant_cnt_r <= 16'h0000;
        end else if (grant_s && (grant_cnt_r != 16'hFFFF)) begin
            grant_cnt_r <= grant_cnt_r + 16'h0001;
        end
    end

    assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_xor_arbiter.sv
// Self-checking bench for xor_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_xor_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      y_out;
    logic [IDW-1:0]        y_id;
    logic                  y_valid;
    logic                  y_ready;
`ifdef XOR_ARBITER_STATS_EN
    logic                  stats_clr;
    logic [15:0]           grant_cnt;
`endif

    xor_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .y_out     (y_out),
        .y_id      (y_id),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
`ifdef XOR_ARBITER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_y;
    int          m_id;
    int          m_cnt;
    int          total;
    int          bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_winner(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Inputs are already driven (just after a posedge); check at negedge, advance model at posedge.
    task automatic step();
        int w;
        logic [NREQ-1:0] eg;
        w  = (!rst && (!m_valid || y_ready)) ? pick_winner(req, m_ptr) : -1;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        @(negedge clk);
        check_val("gnt", 32'(gnt), 32'(eg));
        check_val("y_valid", 32'(y_valid), 32'(m_valid));
        if (m_valid) begin
            check_val("y_out", 32'(y_out), 32'(m_y));
            check_val("y_id", 32'(y_id), 32'(m_id));
        end
`ifdef XOR_ARBITER_STATS_EN
        check_val("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_y = 16'h0; m_id = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_y     = a_in[w*WIDTH +: WIDTH] ^ b_in[w*WIDTH +: WIDTH];
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % NREQ;
        end else if (m_valid && y_ready) begin
            m_valid = 1'b0;
        end
`ifdef XOR_ARBITER_STATS_EN
        if (rst || stats_clr) m_cnt = 0;
        else if (w >= 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`endif
        #1;
    endtask

    task automatic rand_ops();
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
    endtask

    initial begin
        total = 0; bad = 0;
        m_ptr = 0; m_valid = 1'b0; m_y = 16'h0; m_id = 0; m_cnt = 0;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; y_ready = 1'b0;
`ifdef XOR_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        #1;
        check_val("rst_y_out", 32'(y_out), 32'h0);
        check_val("rst_y_id", 32'(y_id), 32'h0);
        check_val("rst_valid", 32'(y_valid), 32'h0);

        // Single request
        req = 4'b0010; y_ready = 1'b1;
        a_in[WIDTH +: WIDTH] = 16'hA5A5; b_in[WIDTH +: WIDTH] = 16'h0FF0;
        #1 check_val("single_gnt", 32'(gnt), 32'h2);
        step();
        check_val("single_y", 32'(y_out), 32'hAA55);
        check_val("single_id", 32'(y_id), 32'h1);
        check_val("single_valid", 32'(y_valid), 32'h1);
        req = '0;
        step();
        check_val("single_drop", 32'(y_valid), 32'h0);

        // Round-robin from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step();
            check_val("rr_id", 32'(y_id), 32'(i % NREQ));
            check_val("rr_valid", 32'(y_valid), 32'h1);
        end

        // Wrap: grant 2 leaves pointer at 3, then 0101 goes to 0 then 2
        req = 4'b0100; rand_ops(); step();
        req = 4'b0101; rand_ops(); step();
        check_val("wrap_first", 32'(y_id), 32'h0);
        rand_ops(); step();
        check_val("wrap_second", 32'(y_id), 32'h2);

        // Back-pressure: grant 0, then stall with 0011 pending
        req = 4'b0001; rand_ops(); step();
        req = 4'b0011; y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops(); step();
            check_val("bp_hold_id", 32'(y_id), 32'h0);
            check_val("bp_hold_valid", 32'(y_valid), 32'h1);
            check_val("bp_gnt", 32'(gnt), 32'h0);
        end
        y_ready = 1'b1;
        #1 check_val("bp_release_gnt", 32'(gnt), 32'h2);
        step();
        check_val("bp_next_id", 32'(y_id), 32'h1);
        check_val("bp_next_valid", 32'(y_valid), 32'h1);

        // Reset while holding a result
        y_ready = 1'b0; rand_ops(); step();
        rst = 1'b1;
        #1 check_val("rst_gnt", 32'(gnt), 32'h0);
        step();
        rst = 1'b0;
        check_val("midrst_valid", 32'(y_valid), 32'h0);
        check_val("midrst_y", 32'(y_out), 32'h0);
        check_val("midrst_id", 32'(y_id), 32'h0);
        req = 4'b1000; y_ready = 1'b1; rand_ops(); step();
        check_val("midrst_next_id", 32'(y_id), 32'h3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req     = NREQ'($urandom);
            y_ready = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            rand_ops();
            step();
        end
        rst = 1'b0;

`ifdef XOR_ARBITER_STATS_EN
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; y_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            rand_ops();
            step();
        end
        check_val("cnt_sat", 32'(grant_cnt), 32'hFFFF);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check_val("cnt_clr", 32'(grant_cnt), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
